// File: rtl/exception_commit_pkg.sv
// Shared types for the commit-stage exception sequencer: CP0 cause codes,
// the wb_exc bit positions, FSM states and the bit-to-cause mapping.
package exception_commit_pkg;

  typedef logic [4:0] ExcCode_t;

  // MIPS32 CP0 Cause.ExcCode values; cERET is a private code for the
  // exception-return path and never reaches Cause as a real fault.
  localparam ExcCode_t cInt     = 5'd0;
  localparam ExcCode_t cTLBMod  = 5'd1;
  localparam ExcCode_t cTLBL    = 5'd2;
  localparam ExcCode_t cTLBS    = 5'd3;
  localparam ExcCode_t cAdEL    = 5'd4;
  localparam ExcCode_t cAdES    = 5'd5;
  localparam ExcCode_t cSyscall = 5'd8;
  localparam ExcCode_t cBp      = 5'd9;
  localparam ExcCode_t cRI      = 5'd10;
  localparam ExcCode_t cCpU     = 5'd11;
  localparam ExcCode_t cOv      = 5'd12;
  localparam ExcCode_t cERET    = 5'd31;

  localparam int EXC_W = 13;

  // Position of each fault in wb_exc; lower index = higher priority.
  typedef enum logic [3:0] {
    EXB_IF_ADEL  = 4'd0,
    EXB_IF_TLBL  = 4'd1,
    EXB_RI       = 4'd2,
    EXB_CPU      = 4'd3,
    EXB_OV       = 4'd4,
    EXB_SYSCALL  = 4'd5,
    EXB_BP       = 4'd6,
    EXB_ERET     = 4'd7,
    EXB_MEM_ADEL = 4'd8,
    EXB_MEM_ADES = 4'd9,
    EXB_MEM_TLBL = 4'd10,
    EXB_MEM_TLBS = 4'd11,
    EXB_TLBMOD   = 4'd12
  } exc_bit_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_WRITE    = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

  // Cause code reported for a given wb_exc bit position.
  function automatic ExcCode_t exc_bit_code(input logic [3:0] idx);
    case (idx)
      EXB_IF_ADEL:  return cAdEL;
      EXB_IF_TLBL:  return cTLBL;
      EXB_RI:       return cRI;
      EXB_CPU:      return cCpU;
      EXB_OV:       return cOv;
      EXB_SYSCALL:  return cSyscall;
      EXB_BP:       return cBp;
      EXB_ERET:     return cERET;
      EXB_MEM_ADEL: return cAdEL;
      EXB_MEM_ADES: return cAdES;
      EXB_MEM_TLBL: return cTLBL;
      EXB_MEM_TLBS: return cTLBS;
      EXB_TLBMOD:   return cTLBMod;
      default:      return cInt;
    endcase
  endfunction

endpackage

// File: rtl/exception_commit_priority_enc.sv
// Fixed-priority cause selector: interrupt beats every flag, then the
// lowest set wb_exc bit wins. Also reports whether the winning fault was
// raised by instruction fetch or by the data access.
module exc_priority_enc
  import exception_commit_pkg::*;
(
  input  logic             interrupt_pending,
  input  logic [EXC_W-1:0] wb_exc,
  output logic             hit,
  output ExcCode_t         code,
  output logic             is_mem,
  output logic             is_fetch
);

  // Scan from lowest priority to highest so the last match wins.
  always_comb begin
    hit      = interrupt_pending | (|wb_exc);
    code     = cInt;
    is_mem   = 1'b0;
    is_fetch = 1'b0;
    if (!interrupt_pending) begin
      for (int i = EXC_W - 1; i >= 0; i--) begin
        if (wb_exc[i]) begin
          code     = exc_bit_code(4'(i));
          is_mem   = (4'(i) >= EXB_MEM_ADEL);
          is_fetch = (4'(i) <= EXB_IF_TLBL);
        end
      end
    end
  end

endmodule

// File: rtl/exception_commit.sv
// Commit-stage exception sequencer: latches the winning cause at trigger,
// waits for memory to drain, pulses the CP0 exception write with flush,
// then holds a fetch redirect until it is accepted.
module exception_commit
  import exception_commit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_valid,
  input  logic [31:0]      wb_pc,
  input  logic             wb_bd,
  input  logic [EXC_W-1:0] wb_exc,
  input  logic             wb_tlb_refill,
  input  logic [31:0]      wb_mem_addr,
  input  logic             interrupt_pending,
  input  logic [31:0]      exc_handler,
  input  logic [31:0]      int_handler,
  input  logic [31:0]      tlb_refill_handler,
  input  logic [31:0]      epc,
  input  logic             mem_busy,
  output logic             en_exp_o,
  output logic             ewr_bd,
  output logic [31:0]      ewr_epc,
  output logic [31:0]      ewr_badVAddr,
  output ExcCode_t         ewr_excCode,
  output logic             wb_stall,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready
);

  state_e      state_reg;
  ExcCode_t    lat_code_reg;
  logic [31:0] lat_epc_reg;
  logic [31:0] lat_badvaddr_reg;
  logic        lat_bd_reg;
  logic        lat_refill_reg;

  logic        enc_hit;
  ExcCode_t    enc_code;
  logic        enc_is_mem;
  logic        enc_is_fetch;

  logic        trigger;
  logic [31:0] live_epc;
  logic [31:0] live_badvaddr;
  logic [31:0] redirect_target;

  exc_priority_enc u_enc (
    .interrupt_pending (interrupt_pending),
    .wb_exc            (wb_exc),
    .hit               (enc_hit),
    .code              (enc_code),
    .is_mem            (enc_is_mem),
    .is_fetch          (enc_is_fetch)
  );

  // Trigger detection and the values captured from the commit stage.
  always_comb begin
    trigger       = wb_valid && enc_hit;
    live_epc      = wb_bd ? (wb_pc - 32'd4) : wb_pc;
    live_badvaddr = enc_is_fetch ? wb_pc : (enc_is_mem ? wb_mem_addr : 32'd0);
    wb_stall      = (state_reg != ST_IDLE) || trigger;
  end

  // Fetch target chosen from CP0 values present during the WRITE cycle.
  always_comb begin
    redirect_target = exc_handler;
    if (lat_code_reg == cERET)
      redirect_target = epc;
    else if (lat_code_reg == cInt)
      redirect_target = int_handler;
    else if ((lat_code_reg == cTLBL || lat_code_reg == cTLBS) && lat_refill_reg)
      redirect_target = tlb_refill_handler;
  end

  // Sequencer FSM with registered CP0 write port and redirect outputs.
  // The ewr_* registers load only on entry to WRITE so CP0 sees values
  // that stay put across a following exception's drain phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      lat_code_reg     <= cInt;
      lat_epc_reg      <= 32'd0;
      lat_badvaddr_reg <= 32'd0;
      lat_bd_reg       <= 1'b0;
      lat_refill_reg   <= 1'b0;
      en_exp_o         <= 1'b0;
      flush            <= 1'b0;
      ewr_bd           <= 1'b0;
      ewr_epc          <= 32'd0;
      ewr_badVAddr     <= 32'd0;
      ewr_excCode      <= cInt;
      redirect_valid   <= 1'b0;
      redirect_pc      <= 32'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (trigger) begin
            lat_code_reg     <= enc_code;
            lat_epc_reg      <= live_epc;
            lat_badvaddr_reg <= live_badvaddr;
            lat_bd_reg       <= wb_bd;
            lat_refill_reg   <= wb_tlb_refill;
            if (mem_busy) begin
              state_reg <= ST_DRAIN;
            end else begin
              state_reg    <= ST_WRITE;
              en_exp_o     <= 1'b1;
              flush        <= 1'b1;
              ewr_bd       <= wb_bd;
              ewr_epc      <= live_epc;
              ewr_badVAddr <= live_badvaddr;
              ewr_excCode  <= enc_code;
            end
          end
        end
        ST_DRAIN: begin
          if (!mem_busy) begin
            state_reg    <= ST_WRITE;
            en_exp_o     <= 1'b1;
            flush        <= 1'b1;
            ewr_bd       <= lat_bd_reg;
            ewr_epc      <= lat_epc_reg;
            ewr_badVAddr <= lat_badvaddr_reg;
            ewr_excCode  <= lat_code_reg;
          end
        end
        ST_WRITE: begin
          en_exp_o       <= 1'b0;
          flush          <= 1'b0;
          redirect_pc    <= redirect_target;
          redirect_valid <= 1'b1;
          state_reg      <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            state_reg      <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_commit.sv
// Self-checking bench for exception_commit: directed scenarios followed by
// randomized exceptions, compared against a transaction-level model.
module tb_exception_commit;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_bd;
  logic [12:0] wb_exc;
  logic        wb_tlb_refill;
  logic [31:0] wb_mem_addr;
  logic        interrupt_pending;
  logic [31:0] exc_handler, int_handler, tlb_refill_handler, epc;
  logic        mem_busy;
  logic        en_exp_o, ewr_bd, wb_stall, flush, redirect_valid, redirect_ready;
  logic [31:0] ewr_epc, ewr_badVAddr, redirect_pc;
  logic [4:0]  ewr_excCode;

  int n_checks = 0;
  int n_fail   = 0;
  int txn_id   = 0;

  always #5 clk = ~clk;

  exception_commit dut (
    .clk                (clk),
    .reset              (reset),
    .wb_valid           (wb_valid),
    .wb_pc              (wb_pc),
    .wb_bd              (wb_bd),
    .wb_exc             (wb_exc),
    .wb_tlb_refill      (wb_tlb_refill),
    .wb_mem_addr        (wb_mem_addr),
    .interrupt_pending  (interrupt_pending),
    .exc_handler        (exc_handler),
    .int_handler        (int_handler),
    .tlb_refill_handler (tlb_refill_handler),
    .epc                (epc),
    .mem_busy           (mem_busy),
    .en_exp_o           (en_exp_o),
    .ewr_bd             (ewr_bd),
    .ewr_epc            (ewr_epc),
    .ewr_badVAddr       (ewr_badVAddr),
    .ewr_excCode        (ewr_excCode),
    .wb_stall           (wb_stall),
    .flush              (flush),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .redirect_ready     (redirect_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model (MIPS cause numbers; ERET uses private code 31) ----
  function automatic logic [4:0] code_of_bit(input int i);
    case (i)
      0: return 5'd4;   1: return 5'd2;   2: return 5'd10;  3: return 5'd11;
      4: return 5'd12;  5: return 5'd8;   6: return 5'd9;   7: return 5'd31;
      8: return 5'd4;   9: return 5'd5;   10: return 5'd2;  11: return 5'd3;
      default: return 5'd1;
    endcase
  endfunction

  function automatic int first_bit(input logic [12:0] e);
    for (int i = 0; i < 13; i++) if (e[i]) return i;
    return -1;
  endfunction

  function automatic logic [4:0] m_code(input logic ip, input logic [12:0] e);
    if (ip) return 5'd0;
    return code_of_bit(first_bit(e));
  endfunction

  function automatic logic [31:0] m_bad(input logic ip, input logic [12:0] e,
                                        input logic [31:0] pc, input logic [31:0] ma);
    int b;
    if (ip) return 32'd0;
    b = first_bit(e);
    if (b <= 1) return pc;
    if (b >= 8) return ma;
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_target(input logic [4:0] c, input logic refill,
                                           input logic [31:0] eh, input logic [31:0] ih,
                                           input logic [31:0] rh, input logic [31:0] ep);
    if (c == 5'd31) return ep;
    if (c == 5'd0) return ih;
    if ((c == 5'd2 || c == 5'd3) && refill) return rh;
    return eh;
  endfunction

  // Drive junk on inputs the DUT must ignore outside the trigger cycle.
  task automatic scramble();
    wb_valid          = 1'($urandom);
    wb_pc             = $urandom;
    wb_bd             = 1'($urandom);
    wb_exc            = 13'($urandom);
    wb_tlb_refill     = 1'($urandom);
    wb_mem_addr       = $urandom;
    interrupt_pending = 1'($urandom);
    exc_handler        = $urandom;
    int_handler        = $urandom;
    tlb_refill_handler = $urandom;
    epc                = $urandom;
  endtask

  // One full exception: trigger, drain, write, redirect, handshake.
  task automatic txn(input logic ip, input logic [12:0] exc, input logic [31:0] pc,
                     input logic bd, input logic [31:0] maddr, input logic refill,
                     input int busy, input int rdelay,
                     input logic [31:0] eh, input logic [31:0] ih,
                     input logic [31:0] rh, input logic [31:0] ep);
    logic [4:0]  xc;
    logic [31:0] xepc, xbad, xtgt;
    xc   = m_code(ip, exc);
    xepc = bd ? pc - 32'd4 : pc;
    xbad = m_bad(ip, exc, pc, maddr);
    xtgt = m_target(xc, refill, eh, ih, rh, ep);

    // trigger cycle
    @(posedge clk); #1;
    scramble();
    wb_valid = 1'b1; wb_pc = pc; wb_bd = bd; wb_exc = exc; wb_tlb_refill = refill;
    wb_mem_addr = maddr; interrupt_pending = ip; mem_busy = (busy > 0);
    redirect_ready = 1'b0;
    @(negedge clk);
    check("trig_stall", 32'(wb_stall), 32'd1);
    check("trig_en", 32'(en_exp_o), 32'd0);

    // drain cycles: mem_busy stays high for 'busy' cycles from the trigger
    for (int c = 1; c <= busy; c++) begin
      @(posedge clk); #1;
      scramble();
      mem_busy = (c < busy);
      @(negedge clk);
      check("drain_en", 32'(en_exp_o), 32'd0);
      check("drain_stall", 32'(wb_stall), 32'd1);
    end

    // write cycle: CP0 handler values presented only now
    @(posedge clk); #1;
    scramble();
    mem_busy = 1'($urandom);
    exc_handler = eh; int_handler = ih; tlb_refill_handler = rh; epc = ep;
    @(negedge clk);
    check("wr_en", 32'(en_exp_o), 32'd1);
    check("wr_flush", 32'(flush), 32'd1);
    check("wr_stall", 32'(wb_stall), 32'd1);
    check("wr_code", 32'(ewr_excCode), 32'(xc));
    check("wr_epc", ewr_epc, xepc);
    check("wr_bad", ewr_badVAddr, xbad);
    check("wr_bd", 32'(ewr_bd), 32'(bd));
    check("wr_rv", 32'(redirect_valid), 32'd0);

    // redirect held until accepted
    for (int r = 0; r <= rdelay; r++) begin
      @(posedge clk); #1;
      scramble();
      mem_busy = 1'($urandom);
      redirect_ready = (r == rdelay);
      @(negedge clk);
      check("rd_valid", 32'(redirect_valid), 32'd1);
      check("rd_pc", redirect_pc, xtgt);
      check("rd_stall", 32'(wb_stall), 32'd1);
      check("rd_en", 32'(en_exp_o), 32'd0);
      check("rd_flush", 32'(flush), 32'd0);
    end

    // back in idle
    @(posedge clk); #1;
    wb_valid = 1'b0; interrupt_pending = 1'b0; redirect_ready = 1'b0; mem_busy = 1'b0;
    @(negedge clk);
    check("idle_rv", 32'(redirect_valid), 32'd0);
    check("idle_stall", 32'(wb_stall), 32'd0);
    check("idle_epc_hold", ewr_epc, xepc);
    $display("txn %0d: code=%0d epc=%h bad=%h target=%h busy=%0d rdelay=%0d",
             txn_id, xc, xepc, xbad, xtgt, busy, rdelay);
    txn_id++;
  endtask

  initial begin
    logic        ip;
    logic [12:0] exc;
    reset = 1'b1; wb_valid = 1'b0; wb_pc = '0; wb_bd = 1'b0; wb_exc = '0;
    wb_tlb_refill = 1'b0; wb_mem_addr = '0; interrupt_pending = 1'b0;
    exc_handler = '0; int_handler = '0; tlb_refill_handler = '0; epc = '0;
    mem_busy = 1'b0; redirect_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_en", 32'(en_exp_o), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_rv", 32'(redirect_valid), 32'd0);
    check("rst_rpc", redirect_pc, 32'd0);
    check("rst_code", 32'(ewr_excCode), 32'd0);
    check("rst_epc", ewr_epc, 32'd0);
    check("rst_bad", ewr_badVAddr, 32'd0);
    check("rst_bd", 32'(ewr_bd), 32'd0);
    check("rst_stall", 32'(wb_stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Syscall, no drain
    txn(1'b0, 13'h0020, 32'h8000_1000, 1'b0, 32'h0, 1'b0, 0, 0,
        32'h8000_0180, 32'h8000_0200, 32'h8000_0000, 32'h0);
    // delay-slot mem AdES
    txn(1'b0, 13'h0200, 32'h8000_2004, 1'b1, 32'h0000_0003, 1'b0, 0, 1,
        32'h8000_0180, 32'h8000_0200, 32'h8000_0000, 32'h0);
    // interrupt + Ov, three drain cycles
    txn(1'b1, 13'h0010, 32'h8000_4000, 1'b0, 32'h0, 1'b0, 3, 0,
        32'h8000_0180, 32'h8000_0200, 32'h8000_0000, 32'h0);
    // mem TLBL refill, redirect stalled 5 cycles
    txn(1'b0, 13'h0400, 32'h8000_5000, 1'b0, 32'h1234_5678, 1'b1, 0, 5,
        32'h8000_0180, 32'h8000_0200, 32'h8000_0000, 32'h0);
    // ERET
    txn(1'b0, 13'h0080, 32'h8000_6000, 1'b0, 32'h0, 1'b0, 0, 0,
        32'h8000_0180, 32'h8000_0200, 32'h8000_0000, 32'h8000_3000);
    // fetch AdEL beats a pending TLBMod
    txn(1'b0, 13'h1001, 32'h8000_7002, 1'b0, 32'hdead_beef, 1'b0, 1, 0,
        32'h8000_0180, 32'h8000_0200, 32'h8000_0000, 32'h0);

    // reset during DRAIN
    @(posedge clk); #1;
    wb_valid = 1'b1; wb_exc = 13'h0100; wb_pc = 32'h8000_8000; wb_mem_addr = 32'h10;
    interrupt_pending = 1'b0; mem_busy = 1'b1;
    @(posedge clk); #1;
    wb_valid = 1'b0; mem_busy = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; mem_busy = 1'b0;
    @(negedge clk);
    check("rstd_en", 32'(en_exp_o), 32'd0);
    check("rstd_flush", 32'(flush), 32'd0);
    check("rstd_rv", 32'(redirect_valid), 32'd0);
    check("rstd_rpc", redirect_pc, 32'd0);
    check("rstd_code", 32'(ewr_excCode), 32'd0);
    check("rstd_epc", ewr_epc, 32'd0);
    check("rstd_bad", ewr_badVAddr, 32'd0);
    check("rstd_bd", 32'(ewr_bd), 32'd0);
    check("rstd_stall", 32'(wb_stall), 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rstd_no_en", 32'(en_exp_o), 32'd0);
      check("rstd_no_rv", 32'(redirect_valid), 32'd0);
    end

    // randomized exceptions
    for (int n = 0; n < 40; n++) begin
      ip = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) exc = 13'($urandom);
      else exc = 13'd1 << $urandom_range(0, 12);
      if (!ip && exc == 13'd0) exc = 13'h0040;
      txn(ip, exc, $urandom, 1'($urandom), $urandom, 1'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom, $urandom, $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
